// File: rtl/multiport_ram_init.sv
`default_nettype none
// ============================================================================
// multiport_ram_init : NUM_RD-read / 1-write synchronous RAM with init sequencer
// Revision 1.0 - initial release
// ============================================================================
module multiport_ram_init #(
    parameter int                DATA_W   = 8,
    parameter int                ADDR_W   = 8,
    parameter int                DEPTH    = 256,
    parameter int                NUM_RD   = 8,
    parameter logic [DATA_W-1:0] INIT_VAL = DATA_W'(1),
    parameter bit                BYPASS   = 1'b1
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_RD-1:0]          rd_en,
    input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
    output logic [NUM_RD*DATA_W-1:0]   rd_data,
    output logic [NUM_RD-1:0]          rd_valid,
    input  logic                       wr_en,
    input  logic [ADDR_W-1:0]          wr_addr,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       init_req,
    output logic                       ready
);

    localparam int                c_idx_w = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0]   c_depth = (ADDR_W+1)'(DEPTH);
    localparam logic [ADDR_W-1:0] c_last  = ADDR_W'(DEPTH - 1);

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                         r_state;
    logic [ADDR_W-1:0]              r_init_ptr;
    logic                           r_ready;
    logic [NUM_RD-1:0]              r_rd_valid;
    logic [NUM_RD-1:0][DATA_W-1:0]  r_rd_data;
    logic [DATA_W-1:0]              r_mem [DEPTH];

    logic                           w_run_ok;
    logic                           w_wr_ok;
    logic                           w_mem_we;
    logic [c_idx_w-1:0]             w_mem_idx;
    logic [DATA_W-1:0]              w_mem_din;
    logic [NUM_RD-1:0][DATA_W-1:0]  w_rd_word;

    // A user write only lands in RUN, in range, and when no re-init is requested
    assign w_run_ok  = (r_state == ST_RUN) && !init_req;
    assign w_wr_ok   = reset && w_run_ok && wr_en && ({1'b0, wr_addr} < c_depth);
    assign w_mem_we  = (reset && (r_state == ST_INIT)) || w_wr_ok;
    assign w_mem_idx = (r_state == ST_INIT) ? r_init_ptr[c_idx_w-1:0] : wr_addr[c_idx_w-1:0];
    assign w_mem_din = (r_state == ST_INIT) ? INIT_VAL : wr_data;

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_idx] <= w_mem_din;
        end
    end

    generate
        for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
            logic [ADDR_W-1:0] w_addr;
            logic              w_in_range;
            logic              w_hit;
            assign w_addr     = rd_addr[g*ADDR_W +: ADDR_W];
            assign w_in_range = ({1'b0, w_addr} < c_depth);
            assign w_hit      = w_wr_ok && (wr_addr == w_addr);
            assign w_rd_word[g] = !w_in_range        ? '0 :
                                  (BYPASS && w_hit)  ? wr_data :
                                                       r_mem[w_addr[c_idx_w-1:0]];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= ST_INIT;
            r_init_ptr <= '0;
            r_ready    <= 1'b0;
            r_rd_valid <= '0;
            r_rd_data  <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    r_rd_valid <= '0;
                    if (r_init_ptr == c_last) begin
                        r_state    <= ST_RUN;
                        r_ready    <= 1'b1;
                        r_init_ptr <= '0;
                    end else begin
                        r_init_ptr <= r_init_ptr + ADDR_W'(1);
                    end
                end
                ST_RUN: begin
                    if (init_req) begin
                        r_state    <= ST_INIT;
                        r_init_ptr <= '0;
                        r_ready    <= 1'b0;
                        r_rd_valid <= '0;
                    end else begin
                        r_rd_valid <= rd_en;
                        for (int i = 0; i < NUM_RD; i++) begin
                            if (rd_en[i]) begin
                                r_rd_data[i] <= w_rd_word[i];
                            end
                        end
                    end
                end
                default: begin
                    r_state    <= ST_INIT;
                    r_init_ptr <= '0;
                    r_ready    <= 1'b0;
                end
            endcase
        end
    end

    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign ready    = r_ready;

endmodule
`default_nettype wire

// File: tb/tb_multiport_ram_init.sv
`default_nettype none
// ============================================================================
// tb_multiport_ram_init : directed bench for three multiport_ram_init variants
// Revision 1.0 - initial release
// ============================================================================
module tb_multiport_ram_init;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  rd_en;
    logic [63:0] rd_addr;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [7:0]  wr_data;
    logic        init_req;

    logic [63:0] rd_data_a, rd_data_b, rd_data_c;
    logic [7:0]  rd_valid_a, rd_valid_b, rd_valid_c;
    logic        ready_a, ready_b, ready_c;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    multiport_ram_init #(.BYPASS(1'b1)) dut_a (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_a), .rd_valid(rd_valid_a), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_req(init_req), .ready(ready_a)
    );

    multiport_ram_init #(.BYPASS(1'b0)) dut_b (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_b), .rd_valid(rd_valid_b), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_req(init_req), .ready(ready_b)
    );

    multiport_ram_init #(.DEPTH(200)) dut_c (
        .clk(clk), .reset(reset), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data_c), .rd_valid(rd_valid_c), .wr_en(wr_en),
        .wr_addr(wr_addr), .wr_data(wr_data), .init_req(init_req), .ready(ready_c)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        rd_en    = '0;
        rd_addr  = '0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        init_req = 1'b0;
    endtask

    // Runs a full init after reset release / init_req and checks the ready edge
    task automatic wait_init(input string tag);
        for (int k = 1; k <= 256; k++) begin
            tick();
            if (k == 199) check({tag, "_c_not_ready"}, 64'(ready_c), 64'd0);
            if (k == 200) check({tag, "_c_ready"},     64'(ready_c), 64'd1);
            if (k == 255) check({tag, "_a_not_ready"}, 64'(ready_a), 64'd0);
            if (k == 256) check({tag, "_a_ready"},     64'(ready_a), 64'd1);
        end
    endtask

    initial begin
        logic [7:0] seen_valid;
        idle();
        reset = 1'b0;
        tick();
        tick();
        check("rst_ready",  64'(ready_a),    64'd0);
        check("rst_valid",  64'(rd_valid_a), 64'd0);
        check("rst_data",   rd_data_a,       64'd0);

        // Reads requested throughout init must be ignored
        reset = 1'b1;
        rd_en = 8'hFF;
        seen_valid = '0;
        for (int k = 1; k <= 256; k++) begin
            tick();
            seen_valid |= rd_valid_a;
            if (k == 199) check("init_c_not_ready", 64'(ready_c), 64'd0);
            if (k == 200) check("init_c_ready",     64'(ready_c), 64'd1);
            if (k == 255) check("init_a_not_ready", 64'(ready_a), 64'd0);
            if (k == 256) check("init_a_ready",     64'(ready_a), 64'd1);
        end
        check("init_no_valid", 64'(seen_valid), 64'd0);
        idle();

        // Eight ports, eight addresses, one cycle
        rd_en   = 8'hFF;
        rd_addr = {8'd255, 8'd191, 8'd128, 8'd127, 8'd64, 8'd63, 8'd1, 8'd0};
        tick();
        check("multi_valid", 64'(rd_valid_a), 64'hFF);
        check("multi_data",  rd_data_a, 64'h0101_0101_0101_0101);
        check("multi_data_d200", rd_data_c, 64'h0001_0101_0101_0101);
        idle();

        // Same-cycle write/read collision on address 3
        rd_en   = 8'h01;
        rd_addr = 64'd3;
        wr_en   = 1'b1;
        wr_addr = 8'd3;
        wr_data = 8'h5A;
        tick();
        check("coll_bypass",   64'(rd_data_a[7:0]), 64'h5A);
        check("coll_nobypass", 64'(rd_data_b[7:0]), 64'h01);
        wr_en = 1'b0;
        tick();
        check("after_coll_b", 64'(rd_data_b[7:0]), 64'h5A);
        check("after_coll_a", 64'(rd_data_a[7:0]), 64'h5A);
        idle();

        // Out-of-range write and read on the 200-deep variant
        wr_en   = 1'b1;
        wr_addr = 8'd220;
        wr_data = 8'hAA;
        tick();
        idle();
        rd_en   = 8'h03;
        rd_addr = {48'd0, 8'd199, 8'd220};
        tick();
        check("oor_valid",    64'(rd_valid_c),      64'h03);
        check("oor_data",     64'(rd_data_c[7:0]),  64'h00);
        check("d200_last",    64'(rd_data_c[15:8]), 64'h01);
        check("inrange_220",  64'(rd_data_a[7:0]),  64'hAA);
        idle();

        // init_req in RUN drops the concurrent write and read
        rd_en   = 8'h01;
        rd_addr = 64'd5;
        wr_en   = 1'b1;
        wr_addr = 8'd10;
        wr_data = 8'h77;
        tick();
        check("pre_req_valid", 64'(rd_valid_a), 64'h01);
        init_req = 1'b1;
        wr_addr  = 8'd11;
        wr_data  = 8'h33;
        rd_addr  = 64'd10;
        tick();
        check("req_ready_drop", 64'(ready_a),    64'd0);
        check("req_valid_drop", 64'(rd_valid_a), 64'd0);
        idle();
        wait_init("req");
        rd_en   = 8'h07;
        rd_addr = {40'd0, 8'd220, 8'd11, 8'd10};
        tick();
        check("req_valid",  64'(rd_valid_a),      64'h07);
        check("req_reinit", 64'(rd_data_a[23:0]), 64'h01_0101);
        idle();

        // Reset part-way through init restarts the sequence
        wr_en   = 1'b1;
        wr_addr = 8'd200;
        wr_data = 8'h42;
        tick();
        idle();
        reset = 1'b0;
        tick();
        check("rst2_data",  rd_data_a,    64'd0);
        check("rst2_ready", 64'(ready_a), 64'd0);
        reset = 1'b1;
        for (int k = 1; k < 100; k++) tick();
        reset = 1'b0;
        tick();
        reset = 1'b1;
        wait_init("restart");
        rd_en   = 8'h01;
        rd_addr = 64'd200;
        tick();
        check("restart_200", 64'(rd_data_a[7:0]), 64'h01);
        idle();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multiport_ram_init.md
Name: multiport_ram_init

Overview:
- Parametrised successor to the fixed 8-read-port byte array.
- Provides NUM_RD synchronous read ports and one synchronous write port over a DEPTH x DATA_W storage array.
- A built-in init sequencer fills every cell with INIT_VAL after reset or on request.
- Sits beside the compute core as its lookup/data table; the core waits for ready before issuing reads.

Parameters:
- DATA_W, 8, data word width in bits
- ADDR_W, 8, address width in bits
- DEPTH, 256, number of words; legal range 2..2**ADDR_W
- NUM_RD, 8, number of independent read ports
- INIT_VAL, 1, value written to every cell by the init sequencer
- BYPASS, 1, 1 = a read that collides with a same-cycle write returns the new data; 0 = it returns the old data

Ports:
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  synchronous, active-low reset
- rd_en  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port i uses bits [i*ADDR_W +: ADDR_W]
- rd_data  out  NUM_RD*DATA_W  packed registered read data; port i uses bits [i*DATA_W +: DATA_W]
- rd_valid  out  NUM_RD  per-port read-data-valid strobe
- wr_en  in  1  write request
- wr_addr  in  ADDR_W  write address
- wr_data  in  DATA_W  write data
- init_req  in  1  one-cycle request to re-run initialisation
- ready  out  1  high when the array is initialised and accepting accesses

Behaviour:
- FSM has two states: INIT and RUN. init_ptr is an ADDR_W-bit counter.
- Reset low at a clock edge:
  - state = INIT, init_ptr = 0
  - ready = 0, rd_valid = 0, rd_data = 0
  - Array contents are not touched directly; the init sequence overwrites them.
- INIT state:
  - Each edge writes INIT_VAL to mem[init_ptr] and increments init_ptr.
  - The edge that writes DEPTH-1 moves to RUN and sets ready = 1.
  - The first edge with reset high writes address 0. ready is therefore seen high after exactly DEPTH edges with reset high.
  - rd_en, wr_en and init_req are ignored; rd_valid stays 0 and rd_data holds its value.
- Reset low during INIT restarts the sequence at address 0.
- RUN state, reads:
  - Latency is 1 cycle: rd_valid[i] <= rd_en[i].
  - When rd_en[i] = 1, rd_data[i] <= mem[rd_addr[i]]. Otherwise rd_data[i] holds.
  - Any number of ports may read the same address in the same cycle.
- RUN state, writes:
  - When wr_en = 1, mem[wr_addr] <= wr_data.
  - The write is visible to reads issued on the following cycle.
- Read/write collision (same cycle, wr_addr == rd_addr[i]):
  - BYPASS = 1: rd_data[i] gets wr_data.
  - BYPASS = 0: rd_data[i] gets the pre-write contents.
- Out of range (address >= DEPTH, only possible when DEPTH < 2**ADDR_W):
  - A read returns 0 with rd_valid = 1.
  - A write is dropped and leaves the array unchanged.
- init_req in RUN:
  - The next edge enters INIT with init_ptr = 0 and ready = 0.
  - A wr_en in the same cycle is dropped.
  - A rd_en in the same cycle is dropped (rd_valid = 0 on the next cycle).
- init_req in INIT has no effect.
- Reset has priority over init_req and all other inputs.
- No storage is larger than DEPTH*DATA_W plus the output registers. Reads are multiplexers on the array and must not replicate the array per port.

Test Plan:
- Default parameters, reset low for 2 edges then high:
  - ready = 0 for the first 255 edges and = 1 after edge 256.
  - rd_valid stays 0 throughout; all outputs are 0 during reset.
- After ready, ports 0..7 read addresses 0, 1, 63, 64, 127, 128, 191, 255 in one cycle:
  - Next cycle, rd_valid = 8'hFF and every rd_data lane = 1.
- Write 0x5A to address 3 with port 0 reading address 3 in the same cycle:
  - BYPASS = 1: port 0 returns 0x5A.
  - BYPASS = 0: port 0 returns 0x01, and a read on the following cycle returns 0x5A.
- Reset low at edge 100 of INIT, then high:
  - Counting restarts; ready rises exactly 256 edges after reset is released.
  - A read of address 200 then returns 1.
- In RUN, write 0x77 to address 10, then assert init_req together with wr_en(addr 11, 0x33):
  - ready drops on the next edge.
  - After 256 edges, addresses 10 and 11 both read 1.
- DEPTH = 200, ADDR_W = 8, after init:
  - Write 0xAA to address 220, then read 220 -> rd_valid = 1, rd_data = 0.
  - Read address 199 -> 1.
